// File: rtl/snax_cgra_pkg.sv
// Shared types and constants for the CGRA <-> TCDM bridge.
// CGRAData layout is {payload, predicate, bypass}, MSB first.
package snax_cgra_pkg;

    typedef struct packed {
        logic [15:0] payload;
        logic        predicate;
        logic        bypass;
    } CGRAData_16_1_1;

    localparam int unsigned CGRADataWidth         = $bits(CGRAData_16_1_1);
    localparam int unsigned MaxOutstandingDefault = 2;

    // Wide enough for any TCDM word up to 1024 bits; callers slice what they need.
    localparam logic [127:0] StrbAllOnes = '1;

    typedef enum logic {
        IDLE,
        REQ
    } req_state_e;

endpackage

// File: rtl/snax_cgra_rsp_fifo.sv
// Small read-response FIFO with count-based full/empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module snax_cgra_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 18,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [Width-1:0] data_i,
    input  logic            pop_i,
    output logic [Width-1:0] data_o,
    output logic            empty_o,
    output logic            full_o,
    output logic [CntW-1:0] count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/snax_cgra_tcdm_bridge.sv
// Bridges CGRA en/rdy load/store ports onto one TCDM request/response port.
// One request register; reads are credit-limited so responses always fit the FIFO.
module snax_cgra_tcdm_bridge
    import snax_cgra_pkg::*;
#(
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned TCDMAddrWidth  = 48,
    parameter int unsigned AddrWidth      = 6,
    parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [TCDMAddrWidth-1:0] base_addr_i,
    input  logic                     recv_waddr_en_i,
    input  logic [AddrWidth-1:0]     recv_waddr_msg_i,
    output logic                     recv_waddr_rdy_o,
    input  logic                     recv_wdata_en_i,
    input  logic [CGRADataWidth-1:0] recv_wdata_msg_i,
    output logic                     recv_wdata_rdy_o,
    input  logic                     recv_raddr_en_i,
    input  logic [AddrWidth-1:0]     recv_raddr_msg_i,
    output logic                     recv_raddr_rdy_o,
    output logic                     send_rdata_en_o,
    output logic [CGRADataWidth-1:0] send_rdata_msg_o,
    input  logic                     send_rdata_rdy_i,
    output logic                     tcdm_q_valid_o,
    input  logic                     tcdm_q_ready_i,
    output logic                     tcdm_write_o,
    output logic [TCDMAddrWidth-1:0] tcdm_addr_o,
    output logic [DataWidth-1:0]     tcdm_data_o,
    output logic [DataWidth/8-1:0]   tcdm_strb_o,
    input  logic                     tcdm_p_valid_i,
    input  logic [DataWidth-1:0]     tcdm_p_data_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

    req_state_e               state_q, state_d;
    logic                     req_write_q;
    logic [TCDMAddrWidth-1:0] req_addr_q;
    logic [DataWidth-1:0]     req_data_q;
    logic [StrbW-1:0]         req_strb_q;
    logic [CntW-1:0]          outstanding_q;
    logic                     err_q;

    CGRAData_16_1_1 wdata, rsp_word;
    logic [AddrWidth-1:0] req_off;
    logic [CntW+1:0]      credit_used;
    logic [CntW-1:0]      fifo_cnt;
    logic fifo_empty, fifo_full, fifo_pop;
    logic wr_offer, req_free, pending_rd, wr_fire, wr_issue, rd_fire;
    logic q_hs, rd_issued, rsp_ok, rsp_err;
    logic unused_bits;

    assign wdata      = recv_wdata_msg_i;
    assign wr_offer   = recv_waddr_en_i && recv_wdata_en_i;
    assign req_free   = (state_q == IDLE) || tcdm_q_ready_i;
    assign pending_rd = (state_q == REQ) && !req_write_q;

    // A read in the request register counts as a credit: it becomes outstanding on handshake.
    assign credit_used = (CntW+2)'(outstanding_q) + (CntW+2)'(fifo_cnt) + (CntW+2)'(pending_rd);

    assign recv_waddr_rdy_o = req_free;
    assign recv_wdata_rdy_o = req_free;
    assign recv_raddr_rdy_o = req_free && !wr_offer && (credit_used < (CntW+2)'(MaxOutstanding));

    assign wr_fire   = req_free && wr_offer;
    assign wr_issue  = wr_fire && wdata.predicate;
    assign rd_fire   = recv_raddr_rdy_o && recv_raddr_en_i;
    assign q_hs      = (state_q == REQ) && tcdm_q_ready_i;
    assign rd_issued = q_hs && !req_write_q;
    assign req_off   = wr_offer ? recv_waddr_msg_i : recv_raddr_msg_i;

    // Stray responses (none outstanding, or no room) are dropped and flagged.
    assign fifo_pop = !fifo_empty && send_rdata_rdy_i;
    assign rsp_ok   = tcdm_p_valid_i && (outstanding_q != '0) && (!fifo_full || fifo_pop);
    assign rsp_err  = tcdm_p_valid_i && !rsp_ok;

    always_comb begin
        state_d = state_q;
        if (wr_issue || rd_fire) state_d = REQ;
        else if (q_hs)           state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_write_q   <= 1'b0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            req_strb_q    <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (wr_issue || rd_fire) begin
                req_write_q <= wr_issue;
                req_addr_q  <= base_addr_i + (TCDMAddrWidth'(req_off) << 3);
                req_data_q  <= wr_issue ? DataWidth'(wdata.payload) : '0;
                req_strb_q  <= wr_issue ? StrbAllOnes[StrbW-1:0] : '0;
            end
            outstanding_q <= outstanding_q + CntW'(rd_issued) - CntW'(rsp_ok);
            if (rsp_err) err_q <= 1'b1;
        end
    end

    assign rsp_word.payload   = tcdm_p_data_i[15:0];
    assign rsp_word.predicate = 1'b1;
    assign rsp_word.bypass    = 1'b0;

    snax_cgra_rsp_fifo #(
        .Depth (MaxOutstanding),
        .Width (CGRADataWidth)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rsp_ok),
        .data_i  (rsp_word),
        .pop_i   (fifo_pop),
        .data_o  (send_rdata_msg_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    assign send_rdata_en_o = fifo_pop;
    assign tcdm_q_valid_o  = (state_q == REQ);
    assign tcdm_write_o    = req_write_q;
    assign tcdm_addr_o     = req_addr_q;
    assign tcdm_data_o     = req_data_q;
    assign tcdm_strb_o     = req_strb_q;
    assign busy_o          = (state_q == REQ) || (outstanding_q != '0) || !fifo_empty;
    assign err_o           = err_q;

    assign unused_bits = ^{tcdm_p_data_i[DataWidth-1:16], wdata.bypass};

endmodule

// File: tb/tb_snax_cgra_tcdm_bridge.sv
// Randomized scoreboard bench for snax_cgra_tcdm_bridge with a memory-level reference model.
module tb_snax_cgra_tcdm_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] base;
    logic        waddr_en, wdata_en, raddr_en;
    logic [5:0]  waddr_msg, raddr_msg;
    logic [17:0] wdata_msg;
    logic        waddr_rdy, wdata_rdy, raddr_rdy;
    logic        send_en, rdata_rdy;
    logic [17:0] send_msg;
    logic        q_valid, q_ready, q_write;
    logic [47:0] q_addr;
    logic [63:0] q_data;
    logic [7:0]  q_strb;
    logic        p_valid;
    logic [63:0] p_data;
    logic        busy, err;

    snax_cgra_tcdm_bridge dut (
        .clk_i(clk), .rst_ni(rst_n), .base_addr_i(base),
        .recv_waddr_en_i(waddr_en), .recv_waddr_msg_i(waddr_msg), .recv_waddr_rdy_o(waddr_rdy),
        .recv_wdata_en_i(wdata_en), .recv_wdata_msg_i(wdata_msg), .recv_wdata_rdy_o(wdata_rdy),
        .recv_raddr_en_i(raddr_en), .recv_raddr_msg_i(raddr_msg), .recv_raddr_rdy_o(raddr_rdy),
        .send_rdata_en_o(send_en), .send_rdata_msg_o(send_msg), .send_rdata_rdy_i(rdata_rdy),
        .tcdm_q_valid_o(q_valid), .tcdm_q_ready_i(q_ready), .tcdm_write_o(q_write),
        .tcdm_addr_o(q_addr), .tcdm_data_o(q_data), .tcdm_strb_o(q_strb),
        .tcdm_p_valid_i(p_valid), .tcdm_p_data_i(p_data), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct { bit w; logic [47:0] a; logic [63:0] d; logic [7:0] s; } req_t;
    typedef struct { logic [63:0] d; int due; } rsp_t;

    req_t        exp_req[$];
    logic [17:0] exp_rd[$];
    rsp_t        rsp_q[$];
    logic [15:0] ref_mem[logic [47:0]];
    logic [63:0] tmem[logic [47:0]];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_send = 0, first_pop = -1;
    int qr_mode = 0, rr_mode = 0, rsp_delay = 0;

    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: event not expected or never happened (cycle %0d)", name, cyc);
    endtask

    function automatic logic [63:0] dflt(input logic [47:0] a);
        return {16'hCAFE, a};
    endfunction

    // Reference model: a word-addressed memory seen from the CGRA side.
    task automatic model_write(input logic [5:0] off, input logic [15:0] pay, input bit pred);
        logic [47:0] a;
        req_t r;
        if (!pred) return;
        a = base + 48'(off) * 48'd8;
        ref_mem[a] = pay;
        r.w = 1'b1; r.a = a; r.d = {48'h0, pay}; r.s = 8'hFF;
        exp_req.push_back(r);
    endtask

    task automatic model_read(input logic [5:0] off);
        logic [47:0] a;
        logic [63:0] dv;
        logic [15:0] v;
        req_t r;
        a = base + 48'(off) * 48'd8;
        dv = dflt(a);
        v = ref_mem.exists(a) ? ref_mem[a] : dv[15:0];
        r.w = 1'b0; r.a = a; r.d = '0; r.s = '0;
        exp_req.push_back(r);
        exp_rd.push_back({v, 1'b1, 1'b0});
    endtask

    // Monitor and TCDM memory: scoreboard on request handshakes and read data pops.
    initial begin
        logic [120:0] prev, cur;
        bit prev_stall = 0;
        req_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin prev_stall = 0; continue; end
            check("rdy_pair", waddr_rdy, wdata_rdy);
            cur = {q_write, q_addr, q_data, q_strb};
            if (prev_stall) check("req_stable", {q_valid, cur}, {1'b1, prev});
            prev_stall = q_valid && !q_ready;
            prev = cur;
            if (q_valid && q_ready) begin
                if (exp_req.size() == 0) fail("unexpected_tcdm_req");
                else begin
                    e = exp_req.pop_front();
                    check("tcdm_req", cur, {e.w, e.a, e.d, e.s});
                end
                if (q_write) tmem[q_addr] = q_data;
                else begin
                    r.d = tmem.exists(q_addr) ? tmem[q_addr] : dflt(q_addr);
                    r.due = cyc + ((rsp_delay < 0) ? int'($urandom_range(0, 4)) : rsp_delay);
                    rsp_q.push_back(r);
                end
            end
            if (send_en) begin
                n_send++;
                if (first_pop < 0) first_pop = cyc;
                if (exp_rd.size() == 0) fail("unexpected_rdata");
                else check("rdata", send_msg, exp_rd.pop_front());
            end
        end
    end

    // TCDM responder: ready policy, in-order delayed read responses.
    initial begin
        rsp_t r;
        q_ready = 1'b1; rdata_rdy = 1'b1; p_valid = 1'b0; p_data = '0;
        forever begin
            @(posedge clk); #1;
            q_ready   = (qr_mode == 0) ? 1'b1 : (qr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            rdata_rdy = (rr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            p_valid = 1'b0;
            if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                p_valid = 1'b1;
                p_data = r.d;
            end
        end
    end

    task automatic do_op(input bit w, input logic [5:0] wo, input logic [15:0] wp, input bit wpred,
                         input bit rd, input logic [5:0] ro, output int w_cyc, output int r_cyc);
        bit wpend = w, rpend = rd;
        int n = 0;
        w_cyc = -1; r_cyc = -1;
        waddr_en = w; wdata_en = w; waddr_msg = wo; wdata_msg = {wp, wpred, 1'b0};
        raddr_en = rd; raddr_msg = ro;
        while ((wpend || rpend) && n < 300) begin
            @(negedge clk);
            if (wpend && rpend) check("write_wins_raddr_rdy", raddr_rdy, 1'b0);
            if (wpend && waddr_rdy) begin model_write(wo, wp, wpred); wpend = 0; w_cyc = cyc; end
            if (rpend && raddr_rdy) begin model_read(ro); rpend = 0; r_cyc = cyc; end
            @(posedge clk); #2;
            if (!wpend) begin waddr_en = 1'b0; wdata_en = 1'b0; end
            if (!rpend) raddr_en = 1'b0;
            n++;
        end
        if (n >= 300) fail("op_timeout");
        waddr_en = 1'b0; wdata_en = 1'b0; raddr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_req.size() != 0 || exp_rd.size() != 0 || busy) && n < 1000) begin
            @(posedge clk); n++;
        end
        if (n >= 1000) fail("drain_timeout");
        #2;
    endtask

    initial begin
        int wc, rc, r1, r2, r3, n;
        rst_n = 1'b0; base = 48'h1000;
        waddr_en = 0; wdata_en = 0; raddr_en = 0;
        waddr_msg = '0; raddr_msg = '0; wdata_msg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {q_valid, send_en, busy, err}, 4'b0000);
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk);
        check("idle_rdy", {waddr_rdy, raddr_rdy}, 2'b11);
        @(posedge clk); #2;

        // Basic write
        do_op(1, 6'd5, 16'hBEEF, 1, 0, 6'd0, wc, rc);
        @(negedge clk);
        check("write_req", {q_valid, q_write, q_addr, q_data, q_strb},
              {1'b1, 1'b1, 48'h1028, 64'hBEEF, 8'hFF});
        @(posedge clk); #2;
        drain();

        // Backpressure on a read of offset 2
        qr_mode = 1; @(posedge clk); #2;
        do_op(0, 6'd0, 16'h0, 0, 1, 6'd2, wc, rc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold", {q_valid, q_addr, raddr_rdy}, {1'b1, 48'h1010, 1'b0});
        end
        qr_mode = 0;
        @(negedge clk);
        check("bp_accept_4th", {q_valid, q_ready}, 2'b11);
        @(posedge clk); #2;
        drain();

        // Credit limit: third read waits for first response to be popped
        rsp_delay = 5; first_pop = -1;
        do_op(0, 0, 0, 0, 1, 6'd1, wc, r1);
        do_op(0, 0, 0, 0, 1, 6'd2, wc, r2);
        do_op(0, 0, 0, 0, 1, 6'd3, wc, r3);
        check("credit_b2b", r2, r1 + 1);
        check("credit_stall", (first_pop >= 0) && (r3 > first_pop), 1'b1);
        drain();

        // Simultaneous write and read, then a predicate-0 write
        rsp_delay = 1;
        do_op(1, 6'd9, 16'h1234, 1, 1, 6'd9, wc, rc);
        check("sim_read_next", rc, wc + 1);
        drain();
        do_op(1, 6'd11, 16'hFFFF, 0, 0, 0, wc, rc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("pred0_no_req", q_valid, 1'b0);
        end
        @(posedge clk); #2;
        do_op(0, 0, 0, 0, 1, 6'd11, wc, rc);
        drain();

        // Address wrap at the top of the TCDM space
        base = 48'hFFFF_FFFF_FFF8;
        do_op(1, 6'd63, 16'h7E57, 1, 0, 0, wc, rc);
        do_op(0, 0, 0, 0, 1, 6'd63, wc, rc);
        do_op(0, 0, 0, 0, 1, 6'd0, wc, rc);
        drain();
        base = 48'h1000;

        // Random mix with random backpressure on both sides
        qr_mode = 2; rr_mode = 2; rsp_delay = -1;
        for (int i = 0; i < 150; i++) begin
            int kind = int'($urandom_range(0, 3));
            logic [5:0] wo = 6'($urandom_range(0, 7));
            logic [5:0] ro = 6'($urandom_range(0, 7));
            logic [15:0] pay = 16'($urandom);
            do_op(kind != 1, wo, pay, kind != 3, kind == 1 || kind == 2, ro, wc, rc);
        end
        qr_mode = 0; rr_mode = 0;
        drain();
        check("no_err_after_random", err, 1'b0);

        // Reset with two reads outstanding; the late responses must flag an error
        rsp_delay = 20;
        do_op(0, 0, 0, 0, 1, 6'd4, wc, rc);
        do_op(0, 0, 0, 0, 1, 6'd5, wc, rc);
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_outputs", {q_valid, send_en, busy, err, waddr_rdy}, 5'b00001);
        @(posedge clk); #2;
        exp_req.delete(); exp_rd.delete();
        rst_n = 1'b1; n_send = 0;
        n = 0;
        while (rsp_q.size() != 0 && n < 60) begin @(posedge clk); n++; end
        if (n >= 60) fail("late_rsp_timeout");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("late_rsp_err", err, 1'b1);
        check("late_rsp_nosend", n_send, 0);
        check("late_rsp_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/snax_cgra_tcdm_bridge.md
SNAX_CGRA_TCDM_BRIDGE -- requirements
Module: snax_cgra_tcdm_bridge

Interface
REQ-001 Parameters SHALL be: DataWidth 64 (TCDM word bits); TCDMAddrWidth 48 (TCDM byte address); AddrWidth 6 (CGRA word offset); MaxOutstanding 2 (read credits, power of two).
REQ-002 Clocking SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be, as name / direction / width / meaning:
- clk_i / in / 1 / clock.
- rst_ni / in / 1 / async active-low reset.
- base_addr_i / in / TCDMAddrWidth / TCDM byte base of the CGRA data region; quasi-static.
- recv_waddr_en_i / in / 1 / write address valid.
- recv_waddr_msg_i / in / AddrWidth / write word offset.
- recv_waddr_rdy_o / out / 1 / write address ready.
- recv_wdata_en_i / in / 1 / write data valid.
- recv_wdata_msg_i / in / 18 / CGRAData {payload[15:0], predicate, bypass}.
- recv_wdata_rdy_o / out / 1 / write data ready.
- recv_raddr_en_i / in / 1 / read address valid.
- recv_raddr_msg_i / in / AddrWidth / read word offset.
- recv_raddr_rdy_o / out / 1 / read address ready.
- send_rdata_en_o / out / 1 / read data valid.
- send_rdata_msg_o / out / 18 / CGRAData read result.
- send_rdata_rdy_i / in / 1 / CGRA can accept read data.
- tcdm_q_valid_o / out / 1 / TCDM request valid.
- tcdm_q_ready_i / in / 1 / TCDM request accepted.
- tcdm_write_o / out / 1 / 1 = write.
- tcdm_addr_o / out / TCDMAddrWidth / byte address.
- tcdm_data_o / out / DataWidth / write data.
- tcdm_strb_o / out / DataWidth/8 / byte strobes.
- tcdm_p_valid_i / in / 1 / read response valid (reads only, in order).
- tcdm_p_data_i / in / DataWidth / read response data.
- busy_o / out / 1 / any request or response in flight.
- err_o / out / 1 / sticky protocol error.

Function
REQ-004 Handshakes SHALL follow CGRA en/rdy: an en is sampled only while the matching rdy is high, and the transfer completes that cycle.
REQ-005 A write SHALL be accepted only when waddr_en and wdata_en are both high in the same cycle; recv_waddr_rdy_o and recv_wdata_rdy_o SHALL be identical.
REQ-006 The request register SHALL hold one entry: state IDLE (empty) or REQ (tcdm_q_valid_o high); the rdy outputs SHALL be high when in IDLE or when REQ and tcdm_q_ready_i are both high.
REQ-007 A request accepted in cycle N SHALL appear on TCDM in cycle N+1; tcdm_* outputs SHALL stay stable while tcdm_q_valid_o is high and tcdm_q_ready_i is low.
REQ-008 tcdm_addr_o SHALL equal base_addr_i + (offset << 3), computed modulo 2^TCDMAddrWidth.
REQ-009 For writes, tcdm_data_o SHALL be the zero-extended payload and tcdm_strb_o SHALL be all ones; for reads, data and strobes SHALL be zero.
REQ-010 A write with predicate 0 SHALL be consumed but SHALL issue no TCDM request.
REQ-011 When a write and a read are both offered in the same cycle, the write SHALL win and recv_raddr_rdy_o SHALL be low.
REQ-012 recv_raddr_rdy_o SHALL additionally require (outstanding reads + FIFO count + pending read in REQ) < MaxOutstanding.
REQ-013 Each tcdm_p_valid_i SHALL decrement the outstanding count and push {p_data[15:0], 1, 0} into a MaxOutstanding-deep FIFO in the same cycle.
REQ-014 send_rdata_en_o SHALL equal (FIFO not empty) AND send_rdata_rdy_i, and SHALL pop the FIFO; push and pop in the same cycle, including when full, SHALL leave the count unchanged.
REQ-015 A tcdm_p_valid_i received with outstanding count 0, or with the FIFO full and no pop, SHALL set err_o, be dropped, and leave all counters unchanged.
REQ-016 busy_o SHALL equal (state REQ) OR (outstanding != 0) OR (FIFO not empty).

Reset
REQ-017 Reset SHALL force state IDLE, outstanding 0, FIFO empty, err_o 0, tcdm_q_valid_o 0, send_rdata_en_o 0, and busy_o 0.
REQ-018 Reset mid-transaction SHALL discard in-flight requests; late responses arriving after reset SHALL set err_o per REQ-015.

Structure
REQ-019 CGRAData_16_1_1 typedef, MaxOutstanding default, and strobe constant SHALL live in the shared package snax_cgra_pkg.
REQ-020 The read FIFO SHALL be sub-module snax_cgra_rsp_fifo (parameterised depth, count-based full/empty); one bridge SHALL be instantiated per TCDM port.

Verification
REQ-021 Write test: base 0x1000, waddr 5, payload 0xBEEF, predicate 1, q_ready 1 -> next cycle q_valid, write 1, addr 0x1028, data 0xBEEF, strb 0xFF.
REQ-022 Backpressure test: q_ready low for 3 cycles during a read of offset 2 -> addr 0x1010 held stable, raddr_rdy low, request accepted on the 4th cycle.
REQ-023 Credit test: 3 back-to-back reads with responses delayed 5 cycles -> third read stalls until the first response returns and is popped; data returned in order.
REQ-024 Simultaneous test: same-cycle write and read offers -> write issued first, read next cycle; predicate-0 write -> no q_valid.
REQ-025 Error/reset test: rst_ni asserted with 2 reads outstanding -> all outputs at reset values; later p_valid -> err_o 1, no send_rdata_en_o.
